// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared ALU types and constants. Holds the serial-subtractor state
//           encoding and the default datapath width.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Default ALU operand/result width.
  localparam int ALU_W = 6;

  // Serial subtractor control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/restador_serial_resta_bit.sv
// ============================================================================
// Module  : resta_bit
// Purpose : Combinational 1-bit full subtractor, computes a - b - bin.
// Ports   : a_i    - minuend bit
//           b_i    - subtrahend bit
//           bin_i  - borrow in
//           d_o    - difference bit
//           bout_o - borrow out
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module resta_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  // Borrow when b exceeds a, or when the bits match and a borrow ripples in.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule : resta_bit

`default_nettype wire

// File: rtl/restador_serial.sv
// ============================================================================
// Module  : restador_serial
// Purpose : Multi-cycle bit-serial subtractor. Computes
//           (num1 - num2 - b_i) mod 2^N one bit per clock, LSB first, using a
//           single full-subtractor cell. start/busy/done handshake.
// Ports   : clk    - clock, rising edge
//           rst    - asynchronous active-high reset
//           start  - request, sampled only when idle
//           num1   - minuend, captured on accepted start
//           num2   - subtrahend, captured on accepted start
//           b_i    - borrow in, captured on accepted start
//           result - difference, held until the next completion
//           b_o    - borrow out, held until the next completion
//           busy   - operation in progress (RUN and FIN)
//           done   - one-cycle pulse while result/b_o are fresh
//           z_o, n_o, v_o - zero/negative/overflow flags
//                    (present only when RESTADOR_FLAGS_EN is defined)
// Config  : RESTADOR_FLAGS_EN - adds the z_o/n_o/v_o flag outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module restador_serial
  import alu_pkg::*;
#(
  parameter int N = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  input  logic         b_i,
  output logic [N-1:0] result,
  output logic         b_o,
  output logic         busy,
  output logic         done
`ifdef RESTADOR_FLAGS_EN
  ,
  output logic         z_o,
  output logic         n_o,
  output logic         v_o
`endif
);

  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            borrow_q;
  // Only N-1 difference bits need storing: the final bit comes straight
  // from the cell in the last RUN cycle.
  logic [N-2:0]    diff_q;
  logic [CW-1:0]   cnt_q;

  logic            bit_d;
  logic            borrow_d;
  logic [N-1:0]    res_d;

`ifdef RESTADOR_FLAGS_EN
  // Operand MSBs are shifted out of a_q/b_q, so keep copies for overflow.
  logic            a_msb_q;
  logic            b_msb_q;
`endif

  resta_bit u_resta_bit (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (borrow_q),
    .d_o    (bit_d),
    .bout_o (borrow_d)
  );

  // Difference register after this cycle's bit is shifted in at the top.
  assign res_d = {bit_d, diff_q};

  // Outputs are committed on the last RUN edge so that result, b_o and
  // done are all valid together during the single FIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      cnt_q    <= '0;
      result   <= '0;
      b_o      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef RESTADOR_FLAGS_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      z_o      <= 1'b0;
      n_o      <= 1'b0;
      v_o      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= num1;
            b_q      <= num2;
            borrow_q <= b_i;
            diff_q   <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
`ifdef RESTADOR_FLAGS_EN
            a_msb_q  <= num1[N-1];
            b_msb_q  <= num2[N-1];
`endif
          end
        end

        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= borrow_d;
          diff_q   <= res_d[N-1:1];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result  <= res_d;
            b_o     <= borrow_d;
            done    <= 1'b1;
            state_q <= FIN;
`ifdef RESTADOR_FLAGS_EN
            z_o     <= (res_d == '0);
            n_o     <= res_d[N-1];
            v_o     <= (a_msb_q != b_msb_q) && (res_d[N-1] != a_msb_q);
`endif
          end
        end

        FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : restador_serial

`default_nettype wire

// File: tb/tb_restador_serial.sv
// ============================================================================
// Module  : tb_restador_serial
// Purpose : Self-checking bench for restador_serial (N=6): directed table,
//           handshake corner cases and randomized operations against an
//           arithmetic reference model.
// Config  : RESTADOR_FLAGS_EN - also connects and checks z_o/n_o/v_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_restador_serial;

  localparam int N = 6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] num1;
  logic [N-1:0] num2;
  logic         b_i;
  logic [N-1:0] result;
  logic         b_o;
  logic         busy;
  logic         done;
  logic         z_o;
  logic         n_o;
  logic         v_o;

  int nchecks = 0;
  int nerr    = 0;
  logic [N-1:0] last_r = '0;
  logic         last_bo = 1'b0;

`ifdef RESTADOR_FLAGS_EN
  restador_serial #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2), .b_i(b_i),
    .result(result), .b_o(b_o), .busy(busy), .done(done),
    .z_o(z_o), .n_o(n_o), .v_o(v_o)
  );
`else
  restador_serial #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2), .b_i(b_i),
    .result(result), .b_o(b_o), .busy(busy), .done(done)
  );
  assign z_o = 1'b0;
  assign n_o = 1'b0;
  assign v_o = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n1; int n2; int b;
    int er; int ebo; int ez; int en; int ev;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic vec_t model(input int n1, input int n2, input int b);
    vec_t v;
    int   diff;
    int   r;
    diff  = n1 - n2 - b;
    r     = (diff + 4 * (1 << N)) % (1 << N);
    v.n1  = n1; v.n2 = n2; v.b = b;
    v.er  = r;
    v.ebo = (diff < 0) ? 1 : 0;
    v.ez  = (r == 0) ? 1 : 0;
    v.en  = (r >= (1 << (N - 1))) ? 1 : 0;
    v.ev  = (((n1 >> (N - 1)) != (n2 >> (N - 1))) &&
             ((r >> (N - 1)) != (n1 >> (N - 1)))) ? 1 : 0;
    return v;
  endfunction

  // Drive a request for the next rising edge (caller ensures DUT idle).
  task automatic drive(input int n1, input int n2, input int b);
    num1  = N'(n1);
    num2  = N'(n2);
    b_i   = b[0];
    start = 1'b1;
  endtask

  // Called right after drive(): follows the op from acceptance to done.
  task automatic run_to_done(input vec_t v, input bit inject);
    int cyc = -1;
    int bc  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        num1  = N'($urandom);
        num2  = N'($urandom);
        b_i   = 1'($urandom);
      end
      if (inject && i == 3) begin
        start = 1'b1; num1 = 6'd10; num2 = 6'd4;
      end
      if (inject && i == 4) start = 1'b0;
      if (busy) bc++;
      if (done) begin
        cyc = i;
        break;
      end
      check("hold_result", int'(result), int'(last_r));
      check("hold_b_o", int'(b_o), int'(last_bo));
    end
    check("done_latency", cyc, N + 1);
    check("busy_cycles", bc, N + 1);
    check("result", int'(result), v.er);
    check("b_o", int'(b_o), v.ebo);
`ifdef RESTADOR_FLAGS_EN
    check("z_o", int'(z_o), v.ez);
    check("n_o", int'(n_o), v.en);
    check("v_o", int'(v_o), v.ev);
`endif
    last_r  = N'(v.er);
    last_bo = v.ebo[0];
  endtask

  task automatic post_check();
    @(negedge clk);
    check("done_pulse_end", int'(done), 0);
    check("busy_end", int'(busy), 0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{63,  2, 0, 61, 0, 0, 1, 0};
    tbl[1] = '{ 0,  1, 0, 63, 1, 0, 1, 0};
    tbl[2] = '{ 5,  5, 1, 63, 1, 0, 1, 0};
    tbl[3] = '{60,  3, 0, 57, 0, 0, 1, 0};
    tbl[4] = '{32,  1, 0, 31, 0, 0, 0, 1};
    tbl[5] = '{ 9,  9, 0,  0, 0, 1, 0, 0};
    tbl[6] = '{ 0, 63, 1,  0, 1, 1, 0, 0};
    tbl[7] = '{63, 63, 1, 63, 1, 0, 1, 0};

    rst = 1'b1; start = 1'b0; num1 = '0; num2 = '0; b_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", int'(result), 0);
    check("rst_b_o", int'(b_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
`ifdef RESTADOR_FLAGS_EN
    check("rst_z", int'(z_o), 0);
    check("rst_n", int'(n_o), 0);
    check("rst_v", int'(v_o), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].n1, tbl[k].n2, tbl[k].b);
      run_to_done(tbl[k], 1'b0);
      post_check();
    end

    // Start while busy is ignored; operands changing mid-op have no effect.
    drive(63, 2, 0);
    run_to_done(model(63, 2, 0), 1'b1);
    post_check();
    @(negedge clk);
    check("ignored_start_busy", int'(busy), 0);

    // Back-to-back: start held in the done cycle is only taken once idle.
    drive(9, 4, 0);
    run_to_done(model(9, 4, 0), 1'b0);
    drive(20, 30, 1);
    @(negedge clk);
    check("b2b_not_accepted_busy", int'(busy), 0);
    check("b2b_not_accepted_done", int'(done), 0);
    run_to_done(model(20, 30, 1), 1'b0);
    post_check();

    // Reset mid-operation aborts with no done pulse.
    drive(60, 3, 0);
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_result", int'(result), 0);
    check("abort_b_o", int'(b_o), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end
    rst = 1'b0;
    last_r = '0;
    last_bo = 1'b0;
    @(negedge clk);
    drive(63, 0, 0);
    run_to_done(model(63, 0, 0), 1'b0);
    post_check();

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      int a;
      int b;
      int c;
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      c = int'($urandom_range(0, 1));
      drive(a, b, c);
      run_to_done(model(a, b, c), 1'b0);
      post_check();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule : tb_restador_serial

`default_nettype wire
